// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle through a full-adder ripple,
// LSB first, with the carry held in a register between digits.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [DIGIT-1:0]       w_dsum;
    logic                   w_dcout;
    logic                   w_msb_cin;
    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH+DIGIT-1:0] w_sum_cat;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // Ripple of DIGIT full adders; also exposes the carry entering the top stage.
    always_comb begin : ripple_comb
        logic       v_c;
        logic       v_cprev;
        logic [1:0] v_fa;
        v_c     = r_carry;
        v_cprev = r_carry;
        v_fa    = 2'b00;
        w_dsum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            v_cprev   = v_c;
            v_fa      = full_add(r_opa[i], r_opb[i], v_c);
            w_dsum[i] = v_fa[0];
            v_c       = v_fa[1];
        end
        w_msb_cin = v_cprev;
        w_dcout   = v_c;
    end

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_cnt == LAST);
    assign w_sum_cat = {w_dsum, r_sum};

    // Next-state logic for the IDLE/RUN/DONE handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, operand shifters, carry, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                // Subtraction is a + ~b + 1, so the carry seeds to 1.
                r_opa   <= a;
                r_opb   <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : cin;
                r_cnt   <= '0;
                r_sum   <= '0;
            end else if (r_state == S_RUN) begin
                r_opa   <= r_opa >> DIGIT;
                r_opb   <= r_opb >> DIGIT;
                r_sum   <= w_sum_cat[WIDTH+DIGIT-1:DIGIT];
                r_carry <= w_dcout;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cout <= w_dcout;
                    r_ovf  <= w_msb_cin ^ w_dcout;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four instances (8/1, 8/4, 4/1, 4/2) checked
// against an integer-arithmetic reference model.
module tb_serial_adder;

    logic clk;
    logic rst;

    logic [7:0] a_v   [4];
    logic [7:0] b_v   [4];
    logic       cin_v [4];
    logic       sub_v [4];
    logic       st_v  [4];
    logic       busy_v[4];
    logic       done_v[4];
    logic       cout_v[4];
    logic       ovf_v [4];
    logic [7:0] sum_v [4];
    logic [7:0] sum_w0;
    logic [7:0] sum_w1;
    logic [3:0] sum_w2;
    logic [3:0] sum_w3;

    int checks = 0;
    int errors = 0;
    int w_t[4] = '{8, 8, 4, 4};
    int n_t[4] = '{8, 2, 4, 2};

    assign sum_v[0] = sum_w0;
    assign sum_v[1] = sum_w1;
    assign sum_v[2] = {4'b0000, sum_w2};
    assign sum_v[3] = {4'b0000, sum_w3};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(st_v[0]), .a(a_v[0]), .b(b_v[0]),
        .cin(cin_v[0]), .sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum_w0), .cout(cout_v[0]), .ovf(ovf_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(st_v[1]), .a(a_v[1]), .b(b_v[1]),
        .cin(cin_v[1]), .sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum_w1), .cout(cout_v[1]), .ovf(ovf_v[1]));

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .start(st_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]),
        .cin(cin_v[2]), .sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .sum(sum_w2), .cout(cout_v[2]), .ovf(ovf_v[2]));

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(st_v[3]), .a(a_v[3][3:0]), .b(b_v[3][3:0]),
        .cin(cin_v[3]), .sub(sub_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .sum(sum_w3), .cout(cout_v[3]), .ovf(ovf_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned/signed integer arithmetic on the operand values.
    function automatic void model(input int w, input int a, input int b, input bit cin,
                                  input bit sub, output int s, output bit co, output bit ov);
        int m;
        int h;
        int sa;
        int sb;
        int r;
        m  = 1 << w;
        h  = 1 << (w - 1);
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        if (sub) begin
            s  = ((a - b) % m + m) % m;
            co = (a >= b);
            r  = sa - sb;
        end else begin
            s  = (a + b + int'(cin)) % m;
            co = (a + b + int'(cin)) >= m;
            r  = sa + sb + int'(cin);
        end
        ov = (r >= h) || (r < -h);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done, counting edges since the accept edge and busy cycles.
    task automatic wait_done(input int k, input string tag, output int edges, output int bcnt);
        edges = 1;
        bcnt  = 0;
        while (done_v[k] !== 1'b1 && edges < 40) begin
            if (busy_v[k] === 1'b1) bcnt++;
            chk({tag, ".busy_and_done"}, {31'd0, busy_v[k] & done_v[k]}, 32'd0);
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ".done_seen"}, {31'd0, done_v[k]}, 32'd1);
    endtask

    task automatic check_result(input int k, input string tag, input int a, input int b,
                                input bit cin, input bit sub);
        int s;
        bit co;
        bit ov;
        model(w_t[k], a, b, cin, sub, s, co, ov);
        chk({tag, ".sum"},  {24'd0, sum_v[k]}, s);
        chk({tag, ".cout"}, {31'd0, cout_v[k]}, {31'd0, co});
        chk({tag, ".ovf"},  {31'd0, ovf_v[k]},  {31'd0, ov});
    endtask

    // One full transaction with operands scrambled after the accept edge.
    task automatic go(input int k, input int a, input int b, input bit cin, input bit sub,
                      input string tag);
        int edges;
        int bcnt;
        int msk;
        msk = (1 << w_t[k]) - 1;
        a_v[k] = 8'(a); b_v[k] = 8'(b); cin_v[k] = cin; sub_v[k] = sub; st_v[k] = 1'b1;
        @(posedge clk); #1;
        st_v[k] = 1'b0;
        a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
        cin_v[k] = 1'($urandom); sub_v[k] = 1'($urandom);
        wait_done(k, tag, edges, bcnt);
        chk({tag, ".latency"}, edges, n_t[k] + 1);
        chk({tag, ".busy_cycles"}, bcnt, n_t[k]);
        check_result(k, tag, a & msk, b & msk, cin, sub);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {31'd0, done_v[k]}, 32'd0);
        check_result(k, {tag, ".hold"}, a & msk, b & msk, cin, sub);
    endtask

    initial begin
        int edges;
        int bcnt;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_v[k] = 8'h00; b_v[k] = 8'h00; cin_v[k] = 1'b0; sub_v[k] = 1'b0; st_v[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset.busy", {31'd0, busy_v[k]}, 32'd0);
            chk("reset.done", {31'd0, done_v[k]}, 32'd0);
            chk("reset.sum",  {24'd0, sum_v[k]}, 32'd0);
            chk("reset.cout", {31'd0, cout_v[k]}, 32'd0);
            chk("reset.ovf",  {31'd0, ovf_v[k]}, 32'd0);
        end
        rst = 1'b0;

        go(0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_01");
        go(0, 8'h7F, 8'h01, 1'b0, 1'b0, "7f_plus_01");
        go(0, 8'h05, 8'h07, 1'b1, 1'b1, "05_minus_07");
        go(1, 8'h80, 8'h80, 1'b1, 1'b0, "d4_80_plus_80");
        go(0, 8'hFF, 8'h01, 1'b0, 1'b0, "pre_reset");

        // Reset mid-RUN discards the partial result and clears the flags.
        a_v[0] = 8'h3C; b_v[0] = 8'h0F; cin_v[0] = 1'b0; sub_v[0] = 1'b0; st_v[0] = 1'b1;
        @(posedge clk); #1;
        st_v[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("midrun.busy_before", {31'd0, busy_v[0]}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun.busy", {31'd0, busy_v[0]}, 32'd0);
        chk("midrun.done", {31'd0, done_v[0]}, 32'd0);
        chk("midrun.sum",  {24'd0, sum_v[0]}, 32'd0);
        chk("midrun.cout", {31'd0, cout_v[0]}, 32'd0);
        chk("midrun.ovf",  {31'd0, ovf_v[0]}, 32'd0);
        @(posedge clk); #1;
        chk("midrun.idle", {31'd0, busy_v[0] | done_v[0]}, 32'd0);
        go(0, 8'h3C, 8'h0F, 1'b1, 1'b0, "after_reset");

        // start held through RUN with new operands, then accepted again in DONE.
        a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0; sub_v[0] = 1'b0; st_v[0] = 1'b1;
        @(posedge clk); #1;
        a_v[0] = 8'hAA; b_v[0] = 8'h55; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        wait_done(0, "hs_first", edges, bcnt);
        chk("hs_first.latency", edges, 32'd9);
        check_result(0, "hs_first", 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1;
        st_v[0] = 1'b0;
        chk("hs_b2b.busy", {31'd0, busy_v[0]}, 32'd1);
        chk("hs_b2b.done", {31'd0, done_v[0]}, 32'd0);
        chk("hs_b2b.sum_cleared", {24'd0, sum_v[0]}, 32'd0);
        wait_done(0, "hs_second", edges, bcnt);
        chk("hs_second.latency", edges, 32'd9);
        check_result(0, "hs_second", 8'hAA, 8'h55, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            go(0, int'($urandom_range(255)), int'($urandom_range(255)),
               1'($urandom), 1'($urandom), "rand_d1");
            go(1, int'($urandom_range(255)), int'($urandom_range(255)),
               1'($urandom), 1'($urandom), "rand_d4");
        end

        for (int k = 2; k < 4; k++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    go(k, x, y, 1'b0, 1'b0, "exh_add0");
                    go(k, x, y, 1'b1, 1'b0, "exh_add1");
                    go(k, x, y, 1'b1, 1'b1, "exh_sub");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
